// File: rtl/tbird_pkg.sv
// Thunderbird tail-light sequencer: shared state encoding and lamp masks.
// Lamp vectors are packed {la, lb, lc, ra, rb, rc}.
package tbird_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        LR3  = 3'd7
    } state_t;

    localparam int STEP_DIV_MIN = 1;
    localparam int STEP_DIV_MAX = 16;

    localparam logic [5:0] LAMP_IDLE = 6'b000_000;
    localparam logic [5:0] LAMP_L1   = 6'b100_000;
    localparam logic [5:0] LAMP_L2   = 6'b110_000;
    localparam logic [5:0] LAMP_L3   = 6'b111_000;
    localparam logic [5:0] LAMP_R1   = 6'b000_100;
    localparam logic [5:0] LAMP_R2   = 6'b000_110;
    localparam logic [5:0] LAMP_R3   = 6'b000_111;
    localparam logic [5:0] LAMP_LR3  = 6'b111_111;

    localparam logic [5:0] BRAKE_ALL   = 6'b111_111;
    localparam logic [5:0] BRAKE_LEFT  = 6'b111_000;
    localparam logic [5:0] BRAKE_RIGHT = 6'b000_111;

    function automatic logic [5:0] lamp_mask(input state_t s);
        logic [5:0] m;
        case (s)
            L1:      m = LAMP_L1;
            L2:      m = LAMP_L2;
            L3:      m = LAMP_L3;
            R1:      m = LAMP_R1;
            R2:      m = LAMP_R2;
            R3:      m = LAMP_R3;
            LR3:     m = LAMP_LR3;
            default: m = LAMP_IDLE;
        endcase
        return m;
    endfunction

    // Braking lights whichever side is not busy signalling a turn.
    function automatic logic [5:0] brake_mask(input state_t s);
        logic [5:0] m;
        case (s)
            IDLE:         m = BRAKE_ALL;
            L1, L2, L3:   m = BRAKE_RIGHT;
            R1, R2, R3:   m = BRAKE_LEFT;
            default:      m = 6'b000_000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tbird_fsm.sv
// Thunderbird tail-light Moore FSM, stepping once every STEP_DIV clk_en pulses.
// Optional brake input enabled by defining TBIRD_BRAKE_EN.
module tbird_fsm
    import tbird_pkg::*;
#(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic left,
    input  logic right,
    input  logic hazard,
`ifdef TBIRD_BRAKE_EN
    input  logic brake,
`endif
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc
);

    localparam int CW = $clog2(STEP_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    if (STEP_DIV < STEP_DIV_MIN || STEP_DIV > STEP_DIV_MAX) begin : g_bad_div
        $error("tbird_fsm: STEP_DIV out of range");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    lamps_q, lamps_d;
    logic          step;

`ifdef TBIRD_BRAKE_EN
    logic brake_q;
`endif

    always_comb begin
        step  = 1'b0;
        cnt_d = cnt_q;
        if (clk_en) begin
            if (cnt_q == LAST) begin
                step  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (step) begin
                if (hazard || (left && right)) state_d = LR3;
                else if (left)                 state_d = L1;
                else if (right)                state_d = R1;
            end
            L1:  if (step) state_d = hazard ? LR3 : L2;
            L2:  if (step) state_d = hazard ? LR3 : L3;
            L3:  if (step) state_d = hazard ? LR3 : IDLE;
            R1:  if (step) state_d = hazard ? LR3 : R2;
            R2:  if (step) state_d = hazard ? LR3 : R3;
            R3:  if (step) state_d = hazard ? LR3 : IDLE;
            LR3: if (step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lamps are registered alongside the state so they move on the same edge.
    always_comb begin
        lamps_d = lamp_mask(state_d);
`ifdef TBIRD_BRAKE_EN
        if (brake) lamps_d = lamps_d | brake_mask(state_d);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lamps_q <= '0;
`ifdef TBIRD_BRAKE_EN
            brake_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lamps_q <= lamps_d;
`ifdef TBIRD_BRAKE_EN
            brake_q <= brake;
`endif
        end
    end

    assign {la, lb, lc, ra, rb, rc} = lamps_q;

endmodule
